// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default widths, the NOP word
// and the packed fetch-word payload carried through the prefetch FIFO.
package instr_fetch_unit_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_INS_W  = 35;
    localparam int unsigned DEF_DEPTH  = 2;

    localparam logic [DEF_INS_W-1:0] NOP = '0;

    // One buffered fetch: the address it came from and the ROM word
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_INS_W-1:0]  ins;
    } fetch_word_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode valid/ready handshake carrying the instruction word and its address.
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned INS_W  = DEF_INS_W
) ();

    logic              ins_valid;
    logic              ins_ready;
    logic [INS_W-1:0]  ins_data;
    logic [ADDR_W-1:0] ins_pc;

    modport master (
        output ins_valid,
        output ins_data,
        output ins_pc,
        input  ins_ready
    );

    modport slave (
        input  ins_valid,
        input  ins_data,
        input  ins_pc,
        output ins_ready
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous prefetch FIFO with flush; a push into a full FIFO is accepted when a pop
// happens in the same cycle, so a full FIFO can stream without a bubble.
module instr_fetch_unit_fetch_fifo #(
    parameter int unsigned WIDTH = 43,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = r_mem[r_head];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_tail <= PTR_W'(r_tail + 1'b1);
            end
            if (w_do_pop) begin
                r_head <= PTR_W'(r_head + 1'b1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= CNT_W'(r_count + 1'b1);
                2'b01:   r_count <= CNT_W'(r_count - 1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush && !reset) begin
            r_mem[r_tail] <= i_wdata;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the PC into the async program ROM, buffers fetched words
// in a prefetch FIFO and hands them to decode; redirects flush the FIFO and reload the PC.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned     ADDR_W   = DEF_ADDR_W,
    parameter int unsigned     INS_W    = DEF_INS_W,
    parameter int unsigned     DEPTH    = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic [ADDR_W-1:0]   o_rom_addr,
    input  logic [INS_W-1:0]    i_rom_data,
    input  logic                i_fetch_en,
    input  logic                i_redirect,
    input  logic [ADDR_W-1:0]   i_redirect_addr,
    output logic                o_busy,
    instr_fetch_unit_if.master  dec_if
);

    localparam int unsigned FW = ADDR_W + INS_W;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [FW-1:0]     w_wdata;
    logic [FW-1:0]     w_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_fetch_en)  w_state_nxt = RUN;
            RUN:     if (!i_fetch_en) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Redirect outranks both push and pop; the FIFO ignores a pop while flushing
    assign w_pop   = ~w_empty & dec_if.ins_ready;
    assign w_push  = (r_state == RUN) & ~i_redirect & (~w_full | w_pop);
    assign w_wdata = {r_pc, i_rom_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= i_redirect_addr;
        end else if (w_push) begin
            r_pc <= ADDR_W'(r_pc + 1'b1);
        end
    end

    instr_fetch_unit_fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_redirect),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign o_rom_addr       = r_pc;
    assign o_busy           = (r_state == RUN) | ~w_empty;
    assign dec_if.ins_valid = ~w_empty;
    assign dec_if.ins_data  = w_empty ? INS_W'(NOP) : w_rdata[INS_W-1:0];
    assign dec_if.ins_pc    = w_empty ? '0 : w_rdata[FW-1:INS_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus queues the expected fetch stream,
// a negedge monitor compares every presented/accepted word against the queue head.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  rom_addr;
    logic [34:0] rom_data;
    logic        fetch_en;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_word_t exp_q[$];

    instr_fetch_unit_if #(.ADDR_W(8), .INS_W(35)) dec_if ();

    instr_fetch_unit #(
        .ADDR_W   (8),
        .INS_W    (35),
        .DEPTH    (2),
        .RESET_PC (8'd0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .o_rom_addr      (rom_addr),
        .i_rom_data      (rom_data),
        .i_fetch_en      (fetch_en),
        .i_redirect      (redirect),
        .i_redirect_addr (redirect_addr),
        .o_busy          (busy),
        .dec_if          (dec_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [34:0] rom_word(input logic [7:0] a);
        return {3'b101, ~a, 16'hC0DE, a};
    endfunction

    // Asynchronous ROM model: address-tagged words
    always_comb rom_data = rom_word(rom_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [7:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            fetch_word_t w;
            w.pc  = 8'(start + 8'(i));
            w.ins = rom_word(w.pc);
            exp_q.push_back(w);
        end
    endtask

    // Monitor: head word must match the queue front; accepted words are popped
    always @(negedge clk) begin
        if (!reset && !redirect) begin
            if (dec_if.ins_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc 0x%0h expected no word", dec_if.ins_pc);
                end else begin
                    check("sb_pc", 64'(dec_if.ins_pc), 64'(exp_q[0].pc));
                    check("sb_data", 64'(dec_if.ins_data), 64'(exp_q[0].ins));
                    if (dec_if.ins_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("idle_data", 64'(dec_if.ins_data), 64'd0);
                check("idle_pc", 64'(dec_if.ins_pc), 64'd0);
            end
        end
    end

    initial begin
        reset            = 1'b1;
        fetch_en         = 1'b0;
        redirect         = 1'b0;
        redirect_addr    = 8'd0;
        dec_if.ins_ready = 1'b0;
        step(2);
        check("rst_valid", 64'(dec_if.ins_valid), 64'd0);
        check("rst_data", 64'(dec_if.ins_data), 64'd0);
        check("rst_pc", 64'(dec_if.ins_pc), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rom_addr", 64'(rom_addr), 64'd0);

        // Sequential stream from 0
        reset            = 1'b0;
        fetch_en         = 1'b1;
        dec_if.ins_ready = 1'b1;
        push_stream(8'd0);
        step(2);
        check("first_valid", 64'(dec_if.ins_valid), 64'd1);
        check("first_pc", 64'(dec_if.ins_pc), 64'd0);
        step(6);
        check("stream_pc6", 64'(dec_if.ins_pc), 64'd6);
        check("stream_rom_addr", 64'(rom_addr), 64'd7);

        // Back-pressure for 5 cycles
        dec_if.ins_ready = 1'b0;
        step(4);
        check("bp_pc", 64'(dec_if.ins_pc), 64'd6);
        check("bp_data", 64'(dec_if.ins_data), 64'(rom_word(8'd6)));
        check("bp_pc_stall", 64'(rom_addr), 64'd8);
        check("bp_busy", 64'(busy), 64'd1);
        step(1);
        dec_if.ins_ready = 1'b1;
        step(1);
        check("bp_release_pc", 64'(dec_if.ins_pc), 64'd7);

        // Redirect to 20 while full
        dec_if.ins_ready = 1'b0;
        step(2);
        check("full_pc_stall", 64'(rom_addr), 64'd9);
        check("full_valid", 64'(dec_if.ins_valid), 64'd1);
        redirect      = 1'b1;
        redirect_addr = 8'd20;
        push_stream(8'd20);
        step(1);
        redirect = 1'b0;
        check("redir_bubble", 64'(dec_if.ins_valid), 64'd0);
        check("redir_rom_addr", 64'(rom_addr), 64'd20);
        dec_if.ins_ready = 1'b1;
        step(1);
        check("redir_valid", 64'(dec_if.ins_valid), 64'd1);
        check("redir_pc20", 64'(dec_if.ins_pc), 64'd20);
        step(1);
        check("redir_pc21", 64'(dec_if.ins_pc), 64'd21);

        // Redirect with a pop in the same cycle, then back-to-back redirects
        step(2);
        check("pre_b2b_pc", 64'(dec_if.ins_pc), 64'd23);
        redirect      = 1'b1;
        redirect_addr = 8'd4;
        push_stream(8'd4);
        step(1);
        check("b2b_valid0", 64'(dec_if.ins_valid), 64'd0);
        check("b2b_rom_addr4", 64'(rom_addr), 64'd4);
        redirect_addr = 8'd16;
        push_stream(8'd16);
        step(1);
        redirect = 1'b0;
        check("b2b_valid1", 64'(dec_if.ins_valid), 64'd0);
        check("b2b_rom_addr16", 64'(rom_addr), 64'd16);
        step(1);
        check("b2b_pc16", 64'(dec_if.ins_pc), 64'd16);
        step(1);
        check("b2b_pc17", 64'(dec_if.ins_pc), 64'd17);

        // PC wrap-around
        redirect      = 1'b1;
        redirect_addr = 8'd254;
        push_stream(8'd254);
        step(1);
        redirect = 1'b0;
        step(1);
        check("wrap_pc254", 64'(dec_if.ins_pc), 64'd254);
        step(1);
        check("wrap_pc255", 64'(dec_if.ins_pc), 64'd255);
        step(1);
        check("wrap_pc0", 64'(dec_if.ins_pc), 64'd0);
        step(1);
        check("wrap_pc1", 64'(dec_if.ins_pc), 64'd1);

        // Reset while two words are buffered
        dec_if.ins_ready = 1'b0;
        step(1);
        check("prerst_pc", 64'(dec_if.ins_pc), 64'd1);
        check("prerst_rom_addr", 64'(rom_addr), 64'd3);
        reset = 1'b1;
        exp_q.delete();
        step(1);
        reset = 1'b0;
        check("mrst_valid", 64'(dec_if.ins_valid), 64'd0);
        check("mrst_rom_addr", 64'(rom_addr), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        dec_if.ins_ready = 1'b1;
        push_stream(8'd0);
        step(2);
        check("mrst_resume_valid", 64'(dec_if.ins_valid), 64'd1);
        check("mrst_resume_pc0", 64'(dec_if.ins_pc), 64'd0);
        step(1);
        check("mrst_resume_pc1", 64'(dec_if.ins_pc), 64'd1);

        // Stop fetching: FIFO drains, PC freezes, then redirect in IDLE
        fetch_en = 1'b0;
        step(4);
        check("stop_busy", 64'(busy), 64'd0);
        check("stop_valid", 64'(dec_if.ins_valid), 64'd0);
        check("stop_rom_addr", 64'(rom_addr), 64'd3);
        redirect      = 1'b1;
        redirect_addr = 8'd100;
        exp_q.delete();
        step(1);
        redirect = 1'b0;
        check("idle_redir_addr", 64'(rom_addr), 64'd100);
        check("idle_redir_busy", 64'(busy), 64'd0);
        step(1);
        check("idle_no_fetch", 64'(rom_addr), 64'd100);
        check("idle_no_valid", 64'(dec_if.ins_valid), 64'd0);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
